score_display: RTL and testbench
================================

# score_display

Four-digit seven-segment display driver for the whack-a-mole game. It sits downstream of the score counter and the game timer. It converts the 6-bit score and 6-bit seconds-remaining values to BCD with a sequential double-dabble engine and time-multiplexes the four digits onto the board's common-anode display. Digit scanning is paced by a 1 kHz single-cycle enable derived in the 100 MHz domain.

## Interface
- `SCAN_DIGITS`, default 4: digits scanned; fixed at 4 for this board.
- `clock`  in  1  100 MHz system clock; the only clock.
- `reset`  in  1  asynchronous, active-low reset.
- `scanTick`  in  1  one-`clock`-wide pulse at 1 kHz; advances the digit scan.
- `displayEnable`  in  1  high while the game is active; when low, all digits are off.
- `score`  in  6  current score, 0–63.
- `timeLeft`  in  6  seconds remaining, 0–63.
- `anode`  out  4  active-low digit selects; bit 0 is the rightmost digit.
- `segment`  out  7  active-low `{g,f,e,d,c,b,a}`.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Digit map.** Digit 0 is score ones, digit 1 is score tens, digit 2 is time ones, digit 3 is time tens.
- **Conversion FSM.** States are IDLE, SHIFT and UPDATE.
  - **IDLE.** Each cycle, compare `{score,timeLeft}` against the stored snapshot. Go to SHIFT on a mismatch or when `forceConv` is set. On that transition, load the snapshot, clear both 8-bit BCD scratch registers, load the shift counter with 6 and clear `forceConv`.
  - **SHIFT.** Run the two double-dabble engines (score and time) in parallel, one bit per cycle. For each nibble ≥5, add 3, then shift the next MSB in. Decrement the counter each cycle; go to UPDATE when it reaches 0 (after the 6th shift).
  - **UPDATE.** Copy the scratch BCD into the four display digit registers, then return to IDLE.
- **Input changes during SHIFT/UPDATE** are ignored. They produce a mismatch in IDLE, which starts a fresh conversion. No value is ever half-displayed.
- **Scan.** A 2-bit index increments on `scanTick` and wraps from 3 to 0. It runs regardless of FSM state.
- **Output.** `anode` drives low only the bit at the current index. `segment` is the decode of that digit register.
- **Leading-zero blanking.** If a tens digit is 0, its `segment` is 7'b1111111 while its anode is still driven.
- **displayEnable low.**
  - `anode` is 4'b1111 and `segment` is 7'b1111111.
  - Conversion and scan continue, so the correct value appears the first cycle enable rises.
- **Segment codes** (active-low):
  - 0=7'b1000000, 1=7'b1111001, 2=7'b0100100, 3=7'b0110000, 4=7'b0011001
  - 5=7'b0010010, 6=7'b0000010, 7=7'b1111000, 8=7'b0000000, 9=7'b0010000
  - Any non-BCD code displays blank.

## Timing
- **Reset values.**
  - Outputs: `anode`=4'b1111, `segment`=7'b1111111, `busy`=0.
  - Internal: FSM=IDLE, scan index=0, digits=0, snapshot=0, `forceConv`=1.
- **Latency.** With a changed input sampled at edge N:
  - Edge N: IDLE→SHIFT.
  - Edges N+1..N+6: shifts, with SHIFT→UPDATE at edge N+6.
  - Edge N+7: digit registers update and the FSM returns to IDLE.
  - The new value is visible on `segment` at edge N+8, when the scan is on that digit.
- **busy** is high from edge N through edge N+7, i.e. during SHIFT and UPDATE.
- **Outputs** are registered and update one cycle after the scan index or digit registers change. `scanTick` at edge M changes `anode` at edge M+1.
- **Back-to-back changes.** Minimum spacing between conversions is 8 cycles. The worst-case display lag is therefore 15 cycles (150 ns), which is invisible at a 1 kHz scan.
- **Simultaneous events.** `scanTick` during UPDATE: both take effect. The new index selects the new digit value at the following edge.
- **Reset mid-conversion** aborts immediately. After release, `forceConv` triggers a conversion of the current inputs.

## Structure
- **`whackamole_pkg`** holds:
  - the segment-code constants SEG_0..SEG_9 and SEG_BLANK;
  - the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, UPDATE=2'd2);
  - the digit-index constants;
  - BCD_W=4.
- **`seven_seg_decoder`** is one combinational sub-module: 4-bit BCD in, 7-bit active-low segments out, blank for values 10–15. It is instantiated once after the digit mux.

## Test plan
- **Reset, then score=0, timeLeft=30, displayEnable=1:**
  - `busy` high 8 cycles, then digits {3,0,0,0}.
  - Scanning shows digit 3 segment 7'b0110000 and digit 1 blank (leading zero).
- **score 9→10:** `segment` for digit 1 becomes 7'b1111001 and for digit 0 becomes 7'b1000000, exactly 8 edges after sampling.
- **Change score 42→43 on the 3rd SHIFT cycle:** display shows 42 first, then a second conversion shows 43. No other value is ever latched.
- **20 `scanTick` pulses:** `anode` cycles 1110→1101→1011→0111→1110, each changing one cycle after the tick.
- **displayEnable=0 with score=63:** `anode`=1111 throughout. On raising enable, the next cycle shows "63" without a new conversion.
- **Assert `reset` during SHIFT:** all outputs go to reset values immediately. After release, the current inputs are converted without any input change.

Source files
------------

// File: rtl/whackamole_pkg.sv
`default_nettype none
// ============================================================================
// Module   : whackamole_pkg
// Purpose  : Shared constants and types for the whack-a-mole display path.
//            It holds the active-low seven-segment codes, the conversion FSM
//            encoding, the digit positions and the double-dabble step helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package whackamole_pkg;

    localparam int BCD_W = 4;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        UPDATE = 2'd2
    } conv_state_t;

    // Digit positions; position 0 is the rightmost digit on the board
    localparam logic [1:0] DIG_SCORE_ONES = 2'd0;
    localparam logic [1:0] DIG_SCORE_TENS = 2'd1;
    localparam logic [1:0] DIG_TIME_ONES  = 2'd2;
    localparam logic [1:0] DIG_TIME_TENS  = 2'd3;

    // One double-dabble iteration on a two-nibble BCD value: adjust every
    // nibble that is 5 or more by +3, then shift the next binary bit in.
    function automatic logic [7:0] dabble_step(input logic [7:0] bcd,
                                               input logic       bit_in);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = bcd[3:0];
        hi = bcd[7:4];
        if (lo >= 4'd5) lo = lo + 4'd3;
        if (hi >= 4'd5) hi = hi + 4'd3;
        return {hi[2:0], lo, bit_in};
    endfunction

endpackage : whackamole_pkg
`default_nettype wire

// File: rtl/seven_seg_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_decoder
// Purpose  : Combinational BCD to active-low seven-segment decoder.
//            Codes 10..15 are not decimal digits and produce a blank digit.
// Ports    : bcd  in  4  BCD digit
//            seg  out 7  active-low segments {g,f,e,d,c,b,a}
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_decoder
    import whackamole_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [6:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule : seven_seg_decoder
`default_nettype wire

// File: rtl/score_display.sv
`default_nettype none
// ============================================================================
// Module   : score_display
// Purpose  : Four-digit multiplexed seven-segment driver. It converts score
//            and seconds-remaining to BCD with a sequential double-dabble
//            engine and scans the digits onto a common-anode display.
// Ports    : clock          in  1  system clock
//            reset          in  1  asynchronous active-low reset
//            scanTick       in  1  single-cycle pulse advancing the digit scan
//            displayEnable  in  1  low blanks every digit
//            score          in  6  score value 0..63
//            timeLeft       in  6  seconds remaining 0..63
//            anode          out 4  active-low digit selects, bit 0 rightmost
//            segment        out 7  active-low segments {g,f,e,d,c,b,a}
//            busy           out 1  high while a conversion is in progress
// Revision : 1.0 - initial release
// ============================================================================
module score_display
    import whackamole_pkg::*;
#(
    parameter int SCAN_DIGITS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       scanTick,
    input  logic       displayEnable,
    input  logic [5:0] score,
    input  logic [5:0] timeLeft,
    output logic [3:0] anode,
    output logic [6:0] segment,
    output logic       busy
);

    conv_state_t      state;
    logic [5:0]       snap_score;
    logic [5:0]       snap_time;
    logic             force_conv;
    logic [2:0]       shift_cnt;
    logic [7:0]       bcd_score;
    logic [7:0]       bcd_time;
    logic [BCD_W-1:0] digits [SCAN_DIGITS];
    logic [1:0]       scan_idx;

    logic             input_changed;
    logic [2:0]       bit_sel;
    logic [BCD_W-1:0] cur_digit;
    logic [6:0]       cur_seg;
    logic             lead_zero;

    assign input_changed = ({score, timeLeft} != {snap_score, snap_time});
    // Bits are taken MSB first from the snapshot, never from the live inputs,
    // so an input change mid-conversion cannot corrupt the result.
    assign bit_sel       = shift_cnt - 3'd1;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            snap_score <= '0;
            snap_time  <= '0;
            force_conv <= 1'b1;
            shift_cnt  <= '0;
            bcd_score  <= '0;
            bcd_time   <= '0;
            busy       <= 1'b0;
            for (int i = 0; i < SCAN_DIGITS; i++) begin
                digits[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (input_changed || force_conv) begin
                        state      <= SHIFT;
                        snap_score <= score;
                        snap_time  <= timeLeft;
                        bcd_score  <= '0;
                        bcd_time   <= '0;
                        shift_cnt  <= 3'd6;
                        force_conv <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    busy      <= 1'b1;
                    bcd_score <= dabble_step(bcd_score, snap_score[bit_sel]);
                    bcd_time  <= dabble_step(bcd_time,  snap_time[bit_sel]);
                    shift_cnt <= shift_cnt - 3'd1;
                    if (shift_cnt == 3'd1) begin
                        state <= UPDATE;
                    end
                end
                UPDATE: begin
                    // busy stays high through this edge and drops on the
                    // first IDLE cycle that does not start a new conversion.
                    busy                   <= 1'b1;
                    digits[DIG_SCORE_ONES] <= bcd_score[3:0];
                    digits[DIG_SCORE_TENS] <= bcd_score[7:4];
                    digits[DIG_TIME_ONES]  <= bcd_time[3:0];
                    digits[DIG_TIME_TENS]  <= bcd_time[7:4];
                    state                  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Digit scan index, free-running on scanTick
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_idx <= '0;
        end else if (scanTick) begin
            scan_idx <= (scan_idx == 2'(SCAN_DIGITS - 1)) ? 2'd0 : scan_idx + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Digit mux, decode and leading-zero blanking
    // ------------------------------------------------------------------
    assign cur_digit = digits[scan_idx];

    seven_seg_decoder u_decoder (
        .bcd (cur_digit),
        .seg (cur_seg)
    );

    assign lead_zero = ((scan_idx == DIG_SCORE_TENS) || (scan_idx == DIG_TIME_TENS))
                       && (cur_digit == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode   <= 4'b1111;
            segment <= SEG_BLANK;
        end else if (!displayEnable) begin
            anode   <= 4'b1111;
            segment <= SEG_BLANK;
        end else begin
            anode   <= ~(4'b0001 << scan_idx);
            segment <= lead_zero ? SEG_BLANK : cur_seg;
        end
    end

endmodule : score_display
`default_nettype wire

// File: tb/tb_score_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_score_display
// Purpose  : Directed self-checking bench for score_display.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_score_display;

    logic       clock = 1'b0;
    logic       reset;
    logic       scanTick;
    logic       displayEnable;
    logic [5:0] score;
    logic [5:0] timeLeft;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       busy;

    int checks    = 0;
    int failures  = 0;
    int idx_model = 0;
    int busy_len  = 0;
    int guard     = 0;

    always #5 clock = ~clock;

    score_display #(.SCAN_DIGITS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .scanTick      (scanTick),
        .displayEnable (displayEnable),
        .score         (score),
        .timeLeft      (timeLeft),
        .anode         (anode),
        .segment       (segment),
        .busy          (busy)
    );

    localparam logic [6:0] BLANK = 7'b1111111;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int i);
        case (i)
            0: return 4'b1110;
            1: return 4'b1101;
            2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse scanTick until the scan sits on digit d, then wait one more edge
    // so the registered outputs reflect that digit.
    task automatic goto_digit(input int d);
        while (idx_model != d) begin
            scanTick = 1'b1;
            @(negedge clock);
            scanTick = 1'b0;
            idx_model = (idx_model + 1) % 4;
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        scanTick      = 1'b0;
        displayEnable = 1'b1;
        score         = 6'd0;
        timeLeft      = 6'd30;
        repeat (3) @(negedge clock);
        check("rst_anode", anode, 4'b1111);
        check("rst_seg", segment, BLANK);
        check("rst_busy", busy, 1'b0);

        // ---- first conversion after reset: 00 / 30 ----
        reset = 1'b1;
        @(negedge clock);
        busy_len = 0;
        guard    = 0;
        while (busy && guard < 30) begin
            busy_len++;
            guard++;
            @(negedge clock);
        end
        check("busy_len", busy_len, 8);
        check("t1_d0_seg", segment, seg_of(0));
        check("t1_d0_an", anode, 4'b1110);
        goto_digit(1);
        check("t1_d1_blank", segment, BLANK);
        check("t1_d1_an", anode, 4'b1101);
        goto_digit(2);
        check("t1_d2_seg", segment, seg_of(0));
        goto_digit(3);
        check("t1_d3_seg", segment, seg_of(3));
        check("t1_d3_an", anode, 4'b0111);

        // ---- score 9 -> 10, exact latency ----
        score = 6'd9;
        repeat (12) @(negedge clock);
        goto_digit(0);
        check("t2_nine", segment, seg_of(9));
        score = 6'd10;
        repeat (8) @(negedge clock);
        check("t2_old_at_n7", segment, seg_of(9));
        @(negedge clock);
        check("t2_new_at_n8", segment, seg_of(0));
        goto_digit(1);
        check("t2_tens", segment, seg_of(1));

        // ---- 42 -> 43 during the third shift ----
        goto_digit(0);
        score = 6'd42;
        repeat (3) @(negedge clock);
        score = 6'd43;
        repeat (4) @(negedge clock);
        @(negedge clock);
        check("t3_k8_old", segment, seg_of(0));
        @(negedge clock);
        check("t3_k9_42", segment, seg_of(2));
        repeat (6) @(negedge clock);
        @(negedge clock);
        check("t3_k16_42", segment, seg_of(2));
        @(negedge clock);
        check("t3_k17_43", segment, seg_of(3));
        goto_digit(1);
        check("t3_tens", segment, seg_of(4));

        // ---- 20 scan ticks ----
        for (int i = 0; i < 20; i++) begin
            scanTick = 1'b1;
            @(negedge clock);
            scanTick = 1'b0;
            check("scan_hold", anode, an_of(idx_model));
            idx_model = (idx_model + 1) % 4;
            @(negedge clock);
            check("scan_step", anode, an_of(idx_model));
        end

        // ---- display disabled while converting 63 ----
        displayEnable = 1'b0;
        score         = 6'd63;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            check("dis_anode", anode, 4'b1111);
        end
        check("dis_seg", segment, BLANK);
        goto_digit(0);
        check("dis_anode_d0", anode, 4'b1111);
        displayEnable = 1'b1;
        @(negedge clock);
        check("en_anode", anode, 4'b1110);
        check("en_seg", segment, seg_of(3));
        check("en_busy", busy, 1'b0);
        goto_digit(1);
        check("en_tens", segment, seg_of(6));

        // ---- reset during SHIFT ----
        goto_digit(0);
        score = 6'd5;
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_anode", anode, 4'b1111);
        check("mid_rst_seg", segment, BLANK);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clock);
        reset     = 1'b1;
        idx_model = 0;
        @(negedge clock);
        check("post_rst_busy", busy, 1'b1);
        repeat (10) @(negedge clock);
        check("post_rst_d0", segment, seg_of(5));
        check("post_rst_an", anode, 4'b1110);
        goto_digit(1);
        check("post_rst_d1", segment, BLANK);
        goto_digit(3);
        check("post_rst_d3", segment, seg_of(3));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_score_display
`default_nettype wire
